fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries (fixed 2 in this revision).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc_pause  input  1  hazard unit: block initiation of new fetch requests.
REQ-006 id_pause  input  1  hazard unit ID-stage hold: keep IF/ID outputs unchanged.
REQ-007 id_bubble  input  1  hazard unit ID-stage bubble: invalidate IF/ID outputs.
REQ-008 redirect_valid  input  1  taken branch/jump/flush redirect.
REQ-009 redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-010 imem_req  output  1  fetch request valid.
REQ-011 imem_addr  output  32  fetch address, word aligned.
REQ-012 imem_ready  input  1  memory accepts request when imem_req&imem_ready.
REQ-013 imem_rvalid  input  1  read data valid, at least one cycle after acceptance.
REQ-014 imem_rdata  input  32  instruction word.
REQ-015 id_valid  output  1  IF/ID register holds a live instruction.
REQ-016 id_pc  output  32  PC of id_instr.
REQ-017 id_instr  output  32  instruction to decode.

Function
REQ-018 SHALL keep at most one accepted-but-unanswered request outstanding.
REQ-019 FSM states SHALL be REQ (may issue), WAIT (one outstanding), KILL (outstanding response to discard).
REQ-020 In REQ, imem_req SHALL equal !pc_pause && !redirect_valid && buffer count < 2; imem_addr SHALL equal pc.
REQ-021 Handshake in REQ SHALL move FSM to WAIT; pc unchanged until response.
REQ-022 imem_rvalid in WAIT SHALL push {pc, imem_rdata} into buffer, set pc <= pc+4 (mod 2^32), return to REQ.
REQ-023 imem_rvalid in KILL SHALL be discarded, FSM to REQ; imem_rvalid in REQ SHALL be ignored.
REQ-024 redirect_valid SHALL set pc <= {redirect_pc[31:2],2'b00}, empty buffer, clear id_valid, in the same edge.
REQ-025 Redirect in WAIT without imem_rvalid, or coincident with a handshake in REQ -> KILL; in WAIT with imem_rvalid -> REQ, data dropped; in KILL -> stays KILL (unless rvalid -> REQ).
REQ-026 IF/ID update priority per edge: redirect_valid or id_bubble (id_valid<=0, buffer not popped) > id_pause (hold all) > advance.
REQ-027 Advance SHALL pop buffer head into id_pc/id_instr with id_valid<=1, or set id_valid<=0 if buffer empty; id_pc/id_instr keep old value when invalid.
REQ-028 Buffer SHALL support simultaneous push and pop, including push into empty buffer in the same edge as pop of nothing (no bypass).
REQ-029 Latency: rvalid at cycle M -> buffer write at edge M -> id_valid high after edge M+1 when not paused.
REQ-030 Push SHALL never occur when buffer full (guaranteed by REQ-020); assertion in bench.

Reset
REQ-031 On rst: pc=RESET_PC, FSM=REQ, buffer empty, imem_req=0, id_valid=0, id_pc=0, id_instr=32'h0000_0013 (NOP).
REQ-032 rst mid-operation SHALL abandon outstanding request; a rvalid arriving in the first cycle after reset SHALL be ignored (FSM in REQ).

Structure
REQ-033 NOP encoding and default RESET_PC SHALL live in the shared riscv defines package, not local literals.
REQ-034 Buffer SHALL be sub-module fetch_buf: 2-entry synchronous FIFO, 64-bit entries, push/pop/flush, count output.

Verification
REQ-035 Reset, imem_ready=1, rvalid 1 cycle later with 0x00500093 -> imem_addr 0x0, then 0x4; id_valid=1, id_pc=0, id_instr=0x00500093 two edges after rvalid.
REQ-036 id_pause held 4 cycles with memory streaming -> buffer fills to 2, imem_req drops, no instruction lost or duplicated; sequential id_pc after release.
REQ-037 Redirect to 0x100 while WAIT, rvalid next cycle with 0xDEADBEEF -> data discarded, next imem_addr 0x100, id_valid low until 0x100 fetched.
REQ-038 Redirect coincident with rvalid, and redirect_pc=0x103 -> no KILL, next imem_addr 0x100.
REQ-039 id_bubble with id_pause both high -> id_valid=0, buffer count unchanged.
REQ-040 pc=0xFFFF_FFFC fetch completes -> next imem_addr 0x0; rst asserted in WAIT -> imem_addr RESET_PC, stray rvalid ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared RISC-V defines for the fetch path.
// Holds the NOP encoding, the default reset PC, the fetch FSM state type
// and the instruction-buffer entry layout used by fetch_unit and fetch_buf.
package fetch_unit_pkg;

  localparam int unsigned XLEN        = 32;
  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,  // free to issue a request
    FS_WAIT = 2'd1,  // one request accepted, response pending
    FS_KILL = 2'd2   // response pending but belongs to a squashed path
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle.
//   imem_req    : fetch request valid (fetch side drives)
//   imem_addr   : word-aligned fetch address (fetch side drives)
//   imem_ready  : memory accepts when imem_req & imem_ready
//   imem_rvalid : read data valid, at least one cycle after acceptance
//   imem_rdata  : instruction word
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_buf.sv
// fetch_buf: 2-entry synchronous FIFO of {pc, instr} entries.
//   clk, rst  : clock, synchronous active-high reset (control only)
//   push_i    : write entry_i at the tail (ignored when full)
//   entry_i   : 64-bit {pc, instr}
//   pop_i     : drop the head (ignored when empty)
//   flush_i   : empty the FIFO; wins over push/pop in the same edge
//   head_o    : current head entry (stale when empty)
//   count_o   : number of live entries
//   empty_o, full_o : occupancy flags
// Push and pop may coincide; a pop while empty is a no-op, so a push into
// an empty FIFO together with a pop lands the entry rather than bypassing it.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is data only; occupancy is tracked by the control state above.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single outstanding memory
// request, a 2-entry instruction buffer and the IF/ID pipeline register.
//   clk, rst        : clock, synchronous active-high reset
//   pc_pause        : block issuing new fetch requests
//   id_pause        : hold IF/ID outputs
//   id_bubble       : invalidate IF/ID outputs
//   redirect_valid  : redirect fetch to redirect_pc (bits [1:0] ignored)
//   redirect_pc     : redirect target
//   imem            : instruction-memory bundle (master side)
//   id_valid        : IF/ID holds a live instruction
//   id_pc, id_instr : PC and instruction word presented to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RV_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_pause,
  input  logic               id_pause,
  input  logic               id_bubble,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic               id_valid,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_instr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;

  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_instr_q, id_instr_d;

  logic         req;
  logic         buf_push;
  logic         buf_pop;
  logic [1:0]   buf_count;
  logic         buf_empty;
  logic         buf_full;
  fetch_entry_t buf_head;
  fetch_entry_t buf_in;

  // Redirect targets are word aligned; the low bits carry no information.
  logic [1:0]   unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[1:0];

  assign buf_in = '{pc: pc_q, instr: imem.imem_rdata};

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (buf_push),
    .entry_i (buf_in),
    .pop_i   (buf_pop),
    .flush_i (redirect_valid),
    .head_o  (buf_head),
    .count_o (buf_count),
    .empty_o (buf_empty),
    .full_o  (buf_full)
  );

  // Fetch FSM and PC. pc only advances when a response is accepted, so
  // imem_addr stays on the outstanding address while in WAIT.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req      = 1'b0;
    buf_push = 1'b0;
    case (state_q)
      FS_REQ: begin
        // Gating on a free buffer slot is what keeps pushes from
        // ever arriving at a full buffer.
        req = !rst && !pc_pause && !redirect_valid && !buf_full;
        if (req && imem.imem_ready)
          state_d = redirect_valid ? FS_KILL : FS_WAIT;
      end
      FS_WAIT: begin
        if (imem.imem_rvalid) begin
          state_d = FS_REQ;
          if (!redirect_valid) begin
            buf_push = 1'b1;
            pc_d     = pc_q + 32'd4;
          end
        end else if (redirect_valid) begin
          state_d = FS_KILL;
        end
      end
      FS_KILL: begin
        if (imem.imem_rvalid) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
    if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  // IF/ID register: squash > hold > advance. A squash never pops, so the
  // buffer (if not also flushed by a redirect) keeps its contents.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    buf_pop    = 1'b0;
    if (redirect_valid || id_bubble) begin
      id_valid_d = 1'b0;
    end else if (!id_pause) begin
      if (!buf_empty) begin
        buf_pop    = 1'b1;
        id_valid_d = 1'b1;
        id_pc_d    = buf_head.pc;
        id_instr_d = buf_head.instr;
      end else begin
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_instr_q <= RV_NOP;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_pause;
  logic        id_pause;
  logic        id_bubble;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int checks;
  int errors;
  int full_errs;
  bit auto_mem;

  fetch_unit_if imem();

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_pause       (pc_pause),
    .id_pause       (id_pause),
    .id_bubble      (id_bubble),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A push into a full buffer must never happen.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(dut.buf_push && dut.buf_count == 2'd2)) else begin
        full_errs++;
        $error("FAIL push_full: observed push with count=%0d expected no push", dut.buf_count);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock. With auto_mem set, a request accepted at this edge is
  // answered during the following cycle with data 0x1000_0000 | addr.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = imem.imem_req && imem.imem_ready;
    a  = imem.imem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem.imem_rvalid = hs;
      imem.imem_rdata  = hs ? (32'h1000_0000 | a) : 32'h0;
    end
  endtask

  initial begin
    checks = 0; errors = 0; full_errs = 0; auto_mem = 1'b0;
    rst = 1'b1; pc_pause = 1'b0; id_pause = 1'b0; id_bubble = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem.imem_ready = 1'b1; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
    tick(); tick();

    // Reset state
    chk("rst_req", imem.imem_req, 1'b0);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    chk("rst_addr", imem.imem_addr, 32'h0);

    // First fetch and latency
    rst = 1'b0; #1;
    chk("t1_req", imem.imem_req, 1'b1);
    chk("t1_addr0", imem.imem_addr, 32'h0);
    tick();
    chk("t1_wait_req", imem.imem_req, 1'b0);
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h0050_0093;
    tick();
    imem.imem_rvalid = 1'b0; imem.imem_ready = 1'b0;
    chk("t1_addr4", imem.imem_addr, 32'h4);
    chk("t1_valid_early", id_valid, 1'b0);
    tick();
    chk("t1_valid", id_valid, 1'b1);
    chk("t1_id_pc", id_pc, 32'h0);
    chk("t1_id_instr", id_instr, 32'h0050_0093);
    tick();
    chk("t1_drain", id_valid, 1'b0);

    // id_pause with streaming memory
    imem.imem_ready = 1'b1; auto_mem = 1'b1; id_pause = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t2_full_req", imem.imem_req, 1'b0);
    chk("t2_full_cnt", dut.buf_count, 2'd2);
    chk("t2_held", id_valid, 1'b0);
    tick();
    chk("t2_full_req2", imem.imem_req, 1'b0);
    id_pause = 1'b0;
    tick();
    chk("t2_v4", id_valid, 1'b1);
    chk("t2_pc4", id_pc, 32'h4);
    chk("t2_in4", id_instr, 32'h1000_0004);
    tick();
    chk("t2_pc8", id_pc, 32'h8);
    chk("t2_in8", id_instr, 32'h1000_0008);
    tick();
    chk("t2_gap", id_valid, 1'b0);
    tick();
    chk("t2_pc12", id_pc, 32'hC);
    pc_pause = 1'b1;
    tick(); tick();
    chk("t2_pc16", id_pc, 32'h10);
    chk("t2_v16", id_valid, 1'b1);
    chk("t2_pcpause", imem.imem_req, 1'b0);

    // Redirect while WAIT, stale response discarded
    pc_pause = 1'b0; auto_mem = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("t3_redir_req", imem.imem_req, 1'b0);
    tick();
    redirect_valid = 1'b0;
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF; #1;
    chk("t3_kill_req", imem.imem_req, 1'b0);
    tick();
    imem.imem_rvalid = 1'b0; imem.imem_ready = 1'b0; #1;
    chk("t3_req", imem.imem_req, 1'b1);
    chk("t3_addr", imem.imem_addr, 32'h100);
    chk("t3_valid", id_valid, 1'b0);
    chk("t3_cnt", dut.buf_count, 2'd0);
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h1111_1111;
    tick();
    imem.imem_rvalid = 1'b0;
    chk("t3_valid2", id_valid, 1'b0);
    tick();
    chk("t3_v100", id_valid, 1'b1);
    chk("t3_pc100", id_pc, 32'h100);
    chk("t3_in100", id_instr, 32'h1111_1111);

    // Redirect coincident with rvalid, unaligned target
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h2222_2222;
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    imem.imem_rvalid = 1'b0; redirect_valid = 1'b0; #1;
    chk("t4_addr", imem.imem_addr, 32'h100);
    chk("t4_req", imem.imem_req, 1'b1);
    tick();
    chk("t4_valid", id_valid, 1'b0);
    chk("t4_cnt", dut.buf_count, 2'd0);

    // id_bubble with id_pause
    id_pause = 1'b1; imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h3333_3333;
    tick();
    imem.imem_rvalid = 1'b0; id_pause = 1'b0;
    tick();
    chk("t5_pc100", id_pc, 32'h100);
    chk("t5_in", id_instr, 32'h3333_3333);
    id_pause = 1'b1; imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h4444_4444;
    tick();
    imem.imem_rvalid = 1'b0;
    chk("t5_hold_v", id_valid, 1'b1);
    chk("t5_hold_pc", id_pc, 32'h100);
    chk("t5_cnt1", dut.buf_count, 2'd1);
    id_bubble = 1'b1;
    tick();
    chk("t5_bub_v", id_valid, 1'b0);
    chk("t5_bub_cnt", dut.buf_count, 2'd1);
    id_bubble = 1'b0; id_pause = 1'b0;
    tick();
    chk("t5_v104", id_valid, 1'b1);
    chk("t5_pc104", id_pc, 32'h104);
    chk("t5_in104", id_instr, 32'h4444_4444);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("t6_addr_top", imem.imem_addr, 32'hFFFF_FFFC);
    chk("t6_redir_v", id_valid, 1'b0);
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h5555_5555;
    tick();
    imem.imem_rvalid = 1'b0;
    chk("t6_wrap", imem.imem_addr, 32'h0);
    tick();
    chk("t6_pc_top", id_pc, 32'hFFFF_FFFC);
    chk("t6_in_top", id_instr, 32'h5555_5555);

    // Reset in WAIT, stray response after reset
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0; imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0; #1;
    chk("t7_wait_req", imem.imem_req, 1'b0);
    chk("t7_wait_addr", imem.imem_addr, 32'h200);
    rst = 1'b1;
    tick();
    chk("t7_rst_addr", imem.imem_addr, 32'h0);
    chk("t7_rst_v", id_valid, 1'b0);
    rst = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h6666_6666; #1;
    chk("t7_req", imem.imem_req, 1'b1);
    tick();
    imem.imem_rvalid = 1'b0;
    chk("t7_stray_cnt", dut.buf_count, 2'd0);
    chk("t7_addr", imem.imem_addr, 32'h0);
    tick();
    chk("t7_stray_v", id_valid, 1'b0);
    chk("t7_nop", id_instr, 32'h0000_0013);

    errors += full_errs;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
